// File: rtl/tdc_top.sv
`timescale 1ps/1ps
// Fine-time front end of a tapped-delay-line TDC: carry-chain delay line, two-stage
// capture/sync of the taps, and a bubble-tolerant popcount with a one-cycle event strobe.
module tdc_top #(
    parameter int unsigned NTAPS        = 12,
    parameter int unsigned TAP_DELAY_PS = 15,
    parameter int unsigned CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hit,
    output logic [NTAPS-1:0] taps,
    output logic [CNT_W-1:0] fine_count,
    output logic             hit_valid
);
    localparam int unsigned NPRIM = NTAPS / 4;

    logic [NTAPS-1:0] w_chain;

`ifdef SYNTHESIS
    // CARRY4 chain; keep it intact and place it as one contiguous column via constraints.
    for (genvar p = 0; p < NPRIM; p++) begin : g_prim
        logic w_ci;
        if (p == 0) begin : g_first
            assign w_ci = hit;
        end else begin : g_next
            assign w_ci = w_chain[4*p-1];
        end
        (* DONT_TOUCH = "TRUE" *)
        CARRY4 u_carry4 (
            .CO     (w_chain[4*p +: 4]),
            .O      (),
            .CI     (w_ci),
            .CYINIT (1'b0),
            .DI     (4'b0000),
            .S      (4'b1111)
        );
    end
`else
    for (genvar i = 0; i < NTAPS; i++) begin : g_tap
        if (i == 0) begin : g_first
            assign #(TAP_DELAY_PS) w_chain[i] = hit;
        end else begin : g_next
            assign #(TAP_DELAY_PS) w_chain[i] = w_chain[i-1];
        end
    end
`endif

    (* ASYNC_REG = "TRUE" *) logic [NTAPS-1:0] r_stage1;
    (* ASYNC_REG = "TRUE" *) logic [NTAPS-1:0] r_stage2;
    logic                    r_prev0;
    logic [2:0]              r_vld;
    logic [CNT_W-1:0]        r_fine_count;
    logic                    r_hit_valid;
    logic [CNT_W-1:0]        w_popcount;
    logic                    w_rise;

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < NTAPS; i++) begin
            w_popcount = w_popcount + CNT_W'(r_stage2[i]);
        end
    end

    // r_vld[2] means r_prev0 holds a real post-reset sample, so a hit already present
    // at reset release is not reported as a new event.
    assign w_rise = r_stage2[0] & ~r_prev0 & r_vld[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage1     <= '0;
            r_stage2     <= '0;
            r_prev0      <= 1'b0;
            r_vld        <= '0;
            r_fine_count <= '0;
            r_hit_valid  <= 1'b0;
        end else begin
            r_stage1     <= w_chain;
            r_stage2     <= r_stage1;
            r_prev0      <= r_stage2[0];
            r_vld        <= {r_vld[1:0], 1'b1};
            r_fine_count <= w_popcount;
            r_hit_valid  <= w_rise;
        end
    end

    assign taps       = r_stage2;
    assign fine_count = r_fine_count;
    assign hit_valid  = r_hit_valid;

endmodule

// File: tb/tb_tdc_top.sv
`timescale 1ps/1ps
// Bench for tdc_top: models the delay-line sample at each edge, queues expected taps and
// encoder outputs, and pops them when the pipeline delivers them.
module tb_tdc_top;
    localparam int unsigned NTAPS  = 12;
    localparam int unsigned TAP_PS = 15;
    localparam int unsigned CNT_W  = 4;

    typedef struct packed {
        logic             hv;
        logic [CNT_W-1:0] cnt;
    } enc_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             hit;
    logic [NTAPS-1:0] taps;
    logic [CNT_W-1:0] fine_count;
    logic             hit_valid;

    logic [NTAPS-1:0] q_taps[$];
    enc_t             q_enc[$];
    logic             lvl;
    logic [NTAPS-1:0] s_prev;
    logic             s_prev_real;
    int               n_checks = 0;
    int               n_pass   = 0;

    tdc_top #(
        .NTAPS        (NTAPS),
        .TAP_DELAY_PS (TAP_PS),
        .CNT_W        (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hit        (hit),
        .taps       (taps),
        .fine_count (fine_count),
        .hit_valid  (hit_valid)
    );

    always #2000 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // One clock cycle starting and ending at a negedge; optionally moves hit 'off' ps
    // before the next rising edge. Pushes the modelled sample, pops due expectations.
    task automatic step(input logic chg, input logic new_lvl, input int unsigned off);
        logic [NTAPS-1:0] s;
        logic [NTAPS-1:0] exp_taps;
        logic             nl;
        enc_t             e;
        nl = chg ? new_lvl : lvl;
        if (chg) begin
            #(2000 - off);
            hit = nl;
        end
        @(posedge clk);
        for (int i = 0; i < NTAPS; i++) begin
            s[i] = (chg && ((i + 1) * TAP_PS >= off)) ? lvl : nl;
        end
        e.hv  = s[0] & ~s_prev[0] & s_prev_real;
        e.cnt = CNT_W'($countones(s));
        q_taps.push_back(s);
        q_enc.push_back(e);
        s_prev      = s;
        s_prev_real = 1'b1;
        lvl         = nl;
        @(negedge clk);
        if (q_taps.size() >= 2) begin
            exp_taps = q_taps.pop_front();
            n_checks++;
            if (taps !== exp_taps)
                $display("FAIL scb_taps: got %h want %h at %0t", taps, exp_taps, $time);
            else n_pass++;
        end
        if (q_enc.size() >= 3) begin
            e = q_enc.pop_front();
            n_checks++;
            if ({hit_valid, fine_count} !== e)
                $display("FAIL scb_enc: got hv=%b cnt=%0d want hv=%b cnt=%0d at %0t",
                         hit_valid, fine_count, e.hv, e.cnt, $time);
            else n_pass++;
        end
    endtask

    task automatic apply_reset(input logic h, input int unsigned edges);
        rst = 1'b1;
        hit = h;
        repeat (edges) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Release at a negedge; the queues are re-primed with the cleared pipeline contents.
    task automatic release_reset();
        enc_t z;
        z   = '0;
        rst = 1'b0;
        q_taps.delete();
        q_enc.delete();
        q_taps.push_back('0);
        q_enc.push_back(z);
        q_enc.push_back(z);
        lvl         = hit;
        s_prev      = '0;
        s_prev_real = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(1'b1, 2);
        n_checks++;
        if (taps !== 12'h000) $display("FAIL reset_taps: got %h want 000", taps); else n_pass++;
        n_checks++;
        if (fine_count !== 4'd0) $display("FAIL reset_cnt: got %0d want 0", fine_count);
        else n_pass++;
        n_checks++;
        if (hit_valid !== 1'b0) $display("FAIL reset_hv: got %b want 0", hit_valid); else n_pass++;
        release_reset();
        // hit already propagated at release must not strobe
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 0);
            n_checks++;
            if (hit_valid !== 1'b0) $display("FAIL reset_nopulse: got %b want 0", hit_valid);
            else n_pass++;
        end
        n_checks++;
        if (taps !== 12'hFFF) $display("FAIL reset_held: got %h want FFF", taps); else n_pass++;
    endtask

    task automatic test_idle();
        step(1'b1, 1'b0, 1000);
        repeat (4) step(1'b0, 1'b0, 0);
        n_checks++;
        if (taps !== 12'h000) $display("FAIL idle_taps: got %h want 000", taps); else n_pass++;
        n_checks++;
        if (fine_count !== 4'd0) $display("FAIL idle_cnt: got %0d want 0", fine_count);
        else n_pass++;
        n_checks++;
        if (hit_valid !== 1'b0) $display("FAIL idle_hv: got %b want 0", hit_valid); else n_pass++;
    endtask

    task automatic test_partial();
        step(1'b1, 1'b1, 40);
        step(1'b0, 1'b0, 0);
        n_checks++;
        if (taps !== 12'h003) $display("FAIL partial_taps: got %h want 003", taps); else n_pass++;
        step(1'b0, 1'b0, 0);
        n_checks++;
        if (fine_count !== 4'd2 || hit_valid !== 1'b1)
            $display("FAIL partial_enc: got cnt=%0d hv=%b want cnt=2 hv=1", fine_count, hit_valid);
        else n_pass++;
        step(1'b0, 1'b0, 0);
        n_checks++;
        if (hit_valid !== 1'b0) $display("FAIL partial_once: got %b want 0", hit_valid);
        else n_pass++;
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 0);
            n_checks++;
            if (taps !== 12'hFFF || fine_count !== 4'd12 || hit_valid !== 1'b0)
                $display("FAIL saturation: got taps=%h cnt=%0d hv=%b want FFF 12 0",
                         taps, fine_count, hit_valid);
            else n_pass++;
        end
    endtask

    task automatic test_mid_chain();
        step(1'b1, 1'b0, 1000);
        repeat (3) step(1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 100);
        step(1'b0, 1'b0, 0);
        n_checks++;
        if (taps !== 12'h03F) $display("FAIL mid_taps: got %h want 03F", taps); else n_pass++;
        step(1'b0, 1'b0, 0);
        n_checks++;
        if (fine_count !== 4'd6 || hit_valid !== 1'b1)
            $display("FAIL mid_enc: got cnt=%0d hv=%b want cnt=6 hv=1", fine_count, hit_valid);
        else n_pass++;
        step(1'b0, 1'b0, 0);
    endtask

    task automatic test_falling();
        repeat (2) step(1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 40);
        step(1'b0, 1'b0, 0);
        n_checks++;
        if (taps !== 12'hFFC) $display("FAIL fall_taps: got %h want FFC", taps); else n_pass++;
        step(1'b0, 1'b0, 0);
        n_checks++;
        if (fine_count !== 4'd10 || hit_valid !== 1'b0)
            $display("FAIL fall_enc: got cnt=%0d hv=%b want cnt=10 hv=0", fine_count, hit_valid);
        else n_pass++;
        step(1'b1, 1'b1, 70);
        step(1'b0, 1'b0, 0);
        n_checks++;
        if (taps !== 12'h00F) $display("FAIL pre_rst_taps: got %h want 00F", taps); else n_pass++;
        // reset lands while the strobe for this event is still in flight
        apply_reset(1'b1, 1);
        n_checks++;
        if (taps !== 12'h000 || fine_count !== 4'd0 || hit_valid !== 1'b0)
            $display("FAIL mid_rst: got taps=%h cnt=%0d hv=%b want 000 0 0",
                     taps, fine_count, hit_valid);
        else n_pass++;
        release_reset();
    endtask

    task automatic test_back_to_back();
        repeat (3) step(1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1000);
        step(1'b1, 1'b1, 40);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        n_checks++;
        if (hit_valid !== 1'b1) $display("FAIL rearm_hv: got %b want 1", hit_valid); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1000);
            step(1'b1, 1'b1, 25 + 30 * k);
            step(1'b0, 1'b0, 0);
        end
        repeat (3) step(1'b0, 1'b0, 0);
    endtask

    initial begin
        rst         = 1'b1;
        hit         = 1'b0;
        lvl         = 1'b0;
        s_prev      = '0;
        s_prev_real = 1'b0;
        @(negedge clk);
        test_reset();
        test_idle();
        test_partial();
        test_saturation();
        test_mid_chain();
        test_falling();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
